// File: rtl/conv10_pkg.sv
// Shared types and default sizing for the conv10 1x1 MAC array sequencer.
package conv10_pkg;

  localparam int CHIN_DEF   = 736;
  localparam int WOUT_DEF   = 8;
  localparam int NPIX_DEF   = WOUT_DEF * WOUT_DEF;
  localparam int AW_IN_DEF  = $clog2(NPIX_DEF * CHIN_DEF);
  localparam int AW_OUT_DEF = $clog2(NPIX_DEF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN1,
    S_ACK1,
    S_GAP,
    S_RUN2,
    S_ACK2,
    S_DONE
  } state_e;

endpackage

// File: rtl/conv10_addr_gen.sv
// ifm read address generator: ch/pix counters with a multiply-free
// per-pixel base accumulator (base += CHIN on each pixel advance).
module conv10_addr_gen #(
  parameter int CHIN  = 736,
  parameter int NPIX  = 64,
  parameter int AW_IN = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             step,
  output logic [AW_IN-1:0] addr
);

  localparam int CW = $clog2(CHIN + 1);
  localparam int PW = (NPIX > 1) ? $clog2(NPIX) : 1;

  localparam logic [CW-1:0]    CH_LAST = CW'(CHIN - 1);
  localparam logic [CW-1:0]    CH_WRAP = CW'(CHIN);
  localparam logic [PW-1:0]    PIX_MAX = PW'(NPIX - 1);
  localparam logic [AW_IN-1:0] CHIN_A  = AW_IN'(CHIN);

  logic [CW-1:0]    ch_q, ch_d;
  logic [PW-1:0]    pix_q, pix_d;
  logic [AW_IN-1:0] base_q, base_d;
  logic [AW_IN-1:0] addr_q, addr_d;

  always_comb begin
    ch_d   = ch_q;
    pix_d  = pix_q;
    base_d = base_q;
    addr_d = addr_q;
    if (clr) begin
      ch_d   = '0;
      pix_d  = '0;
      base_d = '0;
      addr_d = '0;
    end else if (step) begin
      if (ch_q == CH_WRAP) begin
        ch_d = '0;
        // pix saturates; the base then stops advancing too
        if (pix_q != PIX_MAX) begin
          pix_d  = pix_q + 1'b1;
          base_d = base_q + CHIN_A;
        end
        addr_d = base_d;
      end else begin
        ch_d = ch_q + 1'b1;
        if (ch_q != CH_LAST) begin
          addr_d = addr_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q   <= '0;
      pix_q  <= '0;
      base_q <= '0;
      addr_q <= '0;
    end else begin
      ch_q   <= ch_d;
      pix_q  <= pix_d;
      base_q <= base_d;
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/conv10_sched.sv
// conv10 sequencer: runs branch 1 then branch 2 on the shared MAC array.
// Optional perf counters under CONV10_SCHED_PERF_EN.
module conv10_sched
  import conv10_pkg::*;
#(
  parameter int CHIN   = CHIN_DEF,
  parameter int WOUT   = WOUT_DEF,
  parameter int AW_IN  = $clog2(WOUT * WOUT * CHIN),
  parameter int AW_OUT = $clog2(WOUT * WOUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              conv10_1_finish,
  input  logic              conv10_2_finish,
  input  logic              conv10_1_sample,
  output logic              conv10_1_en,
  output logic              conv10_2_en,
  output logic              ram_feedback_1,
  output logic              ram_feedback_2,
  output logic [AW_IN-1:0]  ifm_rd_addr,
  output logic              ofm_wr_en,
  output logic              ofm_wr_sel,
  output logic [AW_OUT-1:0] ofm_wr_addr,
  output logic              busy,
  output logic              done
`ifdef CONV10_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_cyc_1,
  output logic [31:0]       perf_cyc_2,
  output logic [AW_OUT:0]   perf_samples
`endif
);

  localparam int NPIX = WOUT * WOUT;
  localparam logic [AW_OUT-1:0] OUT_LAST = AW_OUT'(NPIX - 1);

  state_e state_q;
  logic   en1_q, en2_q;
  logic   fb1_q, fb2_q;
  logic   busy_q, done_q;

  logic              wr_en_q, wr_sel_q;
  logic [AW_OUT-1:0] wr_addr_q;
  logic [AW_OUT-1:0] out_cnt_q;

  logic run, accept, clr, smp_ok;

  assign run    = (state_q == S_RUN1) || (state_q == S_RUN2);
  assign accept = (state_q == S_IDLE) && start;
  assign clr    = accept || (state_q == S_GAP);
  assign smp_ok = run && conv10_1_sample;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      en1_q   <= 1'b0;
      en2_q   <= 1'b0;
      fb1_q   <= 1'b0;
      fb2_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fb1_q  <= 1'b0;
      fb2_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN1;
            en1_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_RUN1: begin
          if (conv10_1_finish) begin
            state_q <= S_ACK1;
            en1_q   <= 1'b0;
            fb1_q   <= 1'b1;
          end
        end
        S_ACK1: state_q <= S_GAP;
        // one dead cycle so the datapath swaps weight/bias/ifm cleanly
        S_GAP: begin
          state_q <= S_RUN2;
          en2_q   <= 1'b1;
        end
        S_RUN2: begin
          if (conv10_2_finish) begin
            state_q <= S_ACK2;
            en2_q   <= 1'b0;
            fb2_q   <= 1'b1;
          end
        end
        S_ACK2: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_sel_q  <= 1'b0;
      wr_addr_q <= '0;
      out_cnt_q <= '0;
    end else begin
      wr_en_q <= smp_ok;
      if (clr) begin
        out_cnt_q <= '0;
      end else if (smp_ok) begin
        wr_sel_q  <= (state_q == S_RUN2);
        wr_addr_q <= out_cnt_q;
        out_cnt_q <= (out_cnt_q == OUT_LAST) ? '0 : out_cnt_q + 1'b1;
      end
    end
  end

  conv10_addr_gen #(
    .CHIN  (CHIN),
    .NPIX  (NPIX),
    .AW_IN (AW_IN)
  ) u_addr (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .step (run),
    .addr (ifm_rd_addr)
  );

`ifdef CONV10_SCHED_PERF_EN
  logic [31:0]     cyc1_q, cyc2_q;
  logic [AW_OUT:0] nsmp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc1_q <= '0;
      cyc2_q <= '0;
      nsmp_q <= '0;
    end else if (accept) begin
      cyc1_q <= '0;
      cyc2_q <= '0;
      nsmp_q <= '0;
    end else begin
      if (state_q == S_RUN1) cyc1_q <= cyc1_q + 1'b1;
      if (state_q == S_RUN2) cyc2_q <= cyc2_q + 1'b1;
      if (smp_ok && (nsmp_q != '1)) nsmp_q <= nsmp_q + 1'b1;
    end
  end

  assign perf_cyc_1   = cyc1_q;
  assign perf_cyc_2   = cyc2_q;
  assign perf_samples = nsmp_q;
`endif

  assign conv10_1_en    = en1_q;
  assign conv10_2_en    = en2_q;
  assign ram_feedback_1 = fb1_q;
  assign ram_feedback_2 = fb2_q;
  assign ofm_wr_en      = wr_en_q;
  assign ofm_wr_sel     = wr_sel_q;
  assign ofm_wr_addr    = wr_addr_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: doc/conv10_sched.md
Name: conv10_sched

Overview:
- Sequencer for the shared conv10 1x1 MAC array (512 DSP lanes, two weight/bias sets).
- Runs branch conv10_1 to completion, then branch conv10_2, never both at once.
- Generates the ifm read address and ofm write strobes/addresses for the activation RAMs.
- Closes the finish/ram_feedback handshake with the datapath and reports completion to the network-level controller.

Parameters:
- CHIN, 736, input channels per pixel (MAC accumulation length).
- WOUT, 8, output width/height; the layer produces WOUT**2 pixels per branch.
- AW_IN, $clog2(WOUT**2*CHIN), ifm read address width (16 at defaults).
- AW_OUT, $clog2(WOUT**2), ofm write address width (6 at defaults).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; launches both branches.
- conv10_1_finish  in  1  datapath level: branch 1 accumulated all pixels.
- conv10_2_finish  in  1  datapath level: branch 2 accumulated all pixels.
- conv10_1_sample  in  1  datapath pulse: ofm bank valid for one pixel.
- conv10_1_en  out  1  branch-1 enable to datapath.
- conv10_2_en  out  1  branch-2 enable to datapath.
- ram_feedback_1  out  1  one-cycle acknowledge of branch-1 finish.
- ram_feedback_2  out  1  one-cycle acknowledge of branch-2 finish.
- ifm_rd_addr  out  AW_IN  activation RAM read address.
- ofm_wr_en  out  1  ofm RAM write strobe.
- ofm_wr_sel  out  1  0 = write ofm_1 bank, 1 = write ofm_2 bank.
- ofm_wr_addr  out  AW_OUT  ofm RAM pixel address.
- busy  out  1  high from accepted start until DONE.
- done  out  1  one-cycle pulse when both branches are acknowledged.

Behaviour:
- Reset: every output is 0; FSM goes to IDLE; all counters are 0. Reset asserted mid-run aborts immediately; no feedback pulse is issued.
- FSM states: IDLE, RUN1, ACK1, GAP, RUN2, ACK2, DONE.
- IDLE: on start go to RUN1, set busy=1, clear counters. start in any other state is ignored.
- RUN1: conv10_1_en=1.
  - Channel counter ch steps 0..CHIN, period CHIN+1 (matches the datapath clear period).
  - ifm_rd_addr = pix*CHIN + ch while ch<CHIN; it holds its last value during the ch==CHIN bubble.
  - At ch==CHIN, ch wraps to 0 and pix increments. pix saturates at WOUT**2-1.
  - Each conv10_1_sample: ofm_wr_en=1 on the next cycle with ofm_wr_sel=0 and ofm_wr_addr=out_cnt, then out_cnt++. out_cnt wraps to 0 after WOUT**2-1.
  - When conv10_1_finish is seen high, go to ACK1.
- ACK1: conv10_1_en=0; ram_feedback_1=1 for exactly one cycle; go to GAP.
- GAP: one idle cycle with both enables 0, so the datapath mux changes weight/bias/ifm source cleanly; ch, pix and out_cnt are cleared.
- RUN2: identical to RUN1 with conv10_2_en=1, ofm_wr_sel=1, and exit on conv10_2_finish.
- ACK2: ram_feedback_2=1 for one cycle, then go to DONE.
- DONE: done=1 for one cycle, busy=0, then return to IDLE.
- Enable exclusivity: conv10_1_en and conv10_2_en are never high in the same cycle (bench asserts this).
- Simultaneous events:
  - A sample pulse in the same cycle as a finish is still written.
  - conv10_2_finish asserted during RUN1 is ignored.
  - A sample pulse outside RUN1/RUN2 does not write.
- Latency:
  - start to conv10_1_en = 1 cycle.
  - finish to ram_feedback = 1 cycle.
  - conv10_1_finish to conv10_2_en = 3 cycles.
  - All outputs are registered.

Optional Feature:
- Macro: CONV10_SCHED_PERF_EN.
- Defined: adds outputs perf_cyc_1 and perf_cyc_2 (32 bits each), counting cycles spent in RUN1 and RUN2. Both clear on an accepted start and hold their values after DONE. Adds output perf_samples (AW_OUT+1 bits), the total sample pulses accepted in the last run.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package conv10_pkg: FSM state enum typedef, CHIN/WOUT defaults, and the address-width constants.
- One natural sub-module, conv10_addr_gen: the ch/pix counters and the ifm_rd_addr multiply-free accumulator (add CHIN per pixel). Instantiated once and cleared by the FSM.

Test Plan:
- Reset mid-RUN1 (rst high at ch=100) -> all outputs 0 next cycle. A new start then gives ifm_rd_addr sequence 0,1,2,...
- Address sequence: start, run 2 pixels -> ifm_rd_addr 0..735, holds 735 for one cycle, then 736..1471. conv10_1_en stays high throughout.
- Samples: model 64 conv10_1_sample pulses -> 64 ofm_wr_en strobes with sel=0 and addr 0..63; a 65th pulse wraps to addr 0.
- Handoff: assert conv10_1_finish -> ram_feedback_1 one cycle later, one cycle wide. conv10_2_en rises 3 cycles after finish. Enables never overlap.
- Full run: both finishes -> ram_feedback_2 pulse, done pulse one cycle later, busy low. A start pulse during RUN2 has no effect.
- Edge: conv10_2_finish held high during RUN1 -> no early transition. Sample pulse coincident with conv10_2_finish -> still written with sel=1.
